// File: rtl/video_pkg.sv
// Shared video definitions: VGA 640x480 timing, framebuffer geometry and pixel types.
// Used by the timing generator and the VRAM scanout pipeline.
package video_pkg;

   localparam int CNT_W = 10;

   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam int FB_W  = 128;
   localparam int FB_H  = 64;
   localparam int FB_XW = 7;
   localparam int FB_YW = 6;
   localparam int PIX_W = 2;

   typedef logic [PIX_W-1:0] pixel_t;

   // Per-pixel control bits carried alongside the VRAM read.
   typedef struct packed {
      logic hs;
      logic vs;
      logic vis;
      logic win;
   } sync_bits_t;

   function automatic logic in_range(input logic [CNT_W-1:0] val, input int lo, input int hi);
      return (int'(val) >= lo) && (int'(val) < hi);
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters for one VGA frame plus the combinational sync / visible decode.
// Counters advance only on pix_ce; frame_wrap flags the tick that returns to (0,0).
module vga_timing
   import video_pkg::*;
#(
   parameter int H_VISIBLE = video_pkg::H_VISIBLE,
   parameter int H_FRONT   = video_pkg::H_FRONT,
   parameter int H_SYNC    = video_pkg::H_SYNC,
   parameter int H_BACK    = video_pkg::H_BACK,
   parameter int V_VISIBLE = video_pkg::V_VISIBLE,
   parameter int V_FRONT   = video_pkg::V_FRONT,
   parameter int V_SYNC    = video_pkg::V_SYNC,
   parameter int V_BACK    = video_pkg::V_BACK
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_ce,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             hs0,
   output logic             vs0,
   output logic             vis0,
   output logic             frame_wrap
);

   localparam int H_TOT    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOT    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_START = H_VISIBLE + H_FRONT;
   localparam int VS_START = V_VISIBLE + V_FRONT;

   logic [CNT_W-1:0] h_cnt_reg, h_cnt_next;
   logic [CNT_W-1:0] v_cnt_reg, v_cnt_next;
   logic             h_last, v_last;

   always_comb begin
      h_last     = (h_cnt_reg == CNT_W'(H_TOT - 1));
      v_last     = (v_cnt_reg == CNT_W'(V_TOT - 1));
      h_cnt_next = h_last ? '0 : h_cnt_reg + CNT_W'(1);
      v_cnt_next = v_cnt_reg;
      // Line and frame wrap land in the same tick, no extra cycle.
      if (h_last) begin
         v_cnt_next = v_last ? '0 : v_cnt_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt_reg <= '0;
         v_cnt_reg <= '0;
      end else if (pix_ce) begin
         h_cnt_reg <= h_cnt_next;
         v_cnt_reg <= v_cnt_next;
      end
   end

   assign h_cnt      = h_cnt_reg;
   assign v_cnt      = v_cnt_reg;
   assign hs0        = in_range(h_cnt_reg, HS_START, HS_START + H_SYNC);
   assign vs0        = in_range(v_cnt_reg, VS_START, VS_START + V_SYNC);
   assign vis0       = in_range(h_cnt_reg, 0, H_VISIBLE) && in_range(v_cnt_reg, 0, V_VISIBLE);
   assign frame_wrap = h_last && v_last;

endmodule

// File: rtl/vram_scanout.sv
// Reads the 128x64 2bpp framebuffer in raster order and replicates each pixel into a
// centred window of the VGA frame; outputs are two pix_ce ticks behind the counters.
module vram_scanout
   import video_pkg::*;
#(
   parameter int   H_VISIBLE   = video_pkg::H_VISIBLE,
   parameter int   H_FRONT     = video_pkg::H_FRONT,
   parameter int   H_SYNC      = video_pkg::H_SYNC,
   parameter int   H_BACK      = video_pkg::H_BACK,
   parameter int   V_VISIBLE   = video_pkg::V_VISIBLE,
   parameter int   V_FRONT     = video_pkg::V_FRONT,
   parameter int   V_SYNC      = video_pkg::V_SYNC,
   parameter int   V_BACK      = video_pkg::V_BACK,
   parameter int   SCALE_SHIFT = 2,
   parameter int   X_OFFSET    = 64,
   parameter int   Y_OFFSET    = 112,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_ce,
   output logic [FB_XW-1:0] scan_hpos,
   output logic [FB_YW-1:0] scan_vpos,
   input  logic [PIX_W-1:0] scan_pixel,
   output logic             hsync,
   output logic             vsync,
   output logic             video_on,
   output logic [PIX_W-1:0] pixel_out,
   output logic             frame_start
);

   localparam int X_END = X_OFFSET + (FB_W << SCALE_SHIFT);
   localparam int Y_END = Y_OFFSET + (FB_H << SCALE_SHIFT);

   logic [CNT_W-1:0] h_cnt, v_cnt;
   logic [CNT_W-1:0] h_off, v_off;
   logic             hs0, vs0, vis0, frame_wrap;

   sync_bits_t       stage0, stage1_reg;
   logic [FB_XW-1:0] scan_hpos_reg, scan_hpos_next;
   logic [FB_YW-1:0] scan_vpos_reg, scan_vpos_next;
   logic             hsync_reg, vsync_reg, video_on_reg, frame_start_reg;
   pixel_t           pixel_reg, pixel_next;

   vga_timing #(
      .H_VISIBLE (H_VISIBLE),
      .H_FRONT   (H_FRONT),
      .H_SYNC    (H_SYNC),
      .H_BACK    (H_BACK),
      .V_VISIBLE (V_VISIBLE),
      .V_FRONT   (V_FRONT),
      .V_SYNC    (V_SYNC),
      .V_BACK    (V_BACK)
   ) u_timing (
      .clk        (clk),
      .reset      (reset),
      .pix_ce     (pix_ce),
      .h_cnt      (h_cnt),
      .v_cnt      (v_cnt),
      .hs0        (hs0),
      .vs0        (vs0),
      .vis0       (vis0),
      .frame_wrap (frame_wrap)
   );

   // Offsets wrap modulo 2^CNT_W; outside the window the address is don't-care.
   always_comb begin
      h_off          = h_cnt - CNT_W'(X_OFFSET);
      v_off          = v_cnt - CNT_W'(Y_OFFSET);
      scan_hpos_next = FB_XW'(h_off >> SCALE_SHIFT);
      scan_vpos_next = FB_YW'(v_off >> SCALE_SHIFT);
      stage0.hs      = hs0;
      stage0.vs      = vs0;
      stage0.vis     = vis0;
      stage0.win     = vis0 && in_range(h_cnt, X_OFFSET, X_END)
                            && in_range(v_cnt, Y_OFFSET, Y_END);
      pixel_next     = stage1_reg.win ? pixel_t'(scan_pixel) : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         scan_hpos_reg   <= '0;
         scan_vpos_reg   <= '0;
         stage1_reg      <= '0;
         hsync_reg       <= ~SYNC_ACTIVE;
         vsync_reg       <= ~SYNC_ACTIVE;
         video_on_reg    <= 1'b0;
         pixel_reg       <= '0;
         frame_start_reg <= 1'b0;
      end else begin
         // Re-evaluated every clk so the pulse never outlasts one clk.
         frame_start_reg <= pix_ce && frame_wrap;
         if (pix_ce) begin
            scan_hpos_reg <= scan_hpos_next;
            scan_vpos_reg <= scan_vpos_next;
            stage1_reg    <= stage0;
            hsync_reg     <= stage1_reg.hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_reg     <= stage1_reg.vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            video_on_reg  <= stage1_reg.vis;
            pixel_reg     <= pixel_next;
         end
      end
   end

   assign scan_hpos   = scan_hpos_reg;
   assign scan_vpos   = scan_vpos_reg;
   assign hsync       = hsync_reg;
   assign vsync       = vsync_reg;
   assign video_on    = video_on_reg;
   assign pixel_out   = pixel_reg;
   assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vram_scanout.sv
// Self-checking bench for vram_scanout using a reduced timing set (2x scaling) so that
// whole frames fit in a short run; expected values come from a raster model and a table.
module tb_vram_scanout;

   localparam int TH_VIS = 272, TH_FRONT = 4, TH_SYNC = 8, TH_BACK = 4;
   localparam int TV_VIS = 136, TV_FRONT = 2, TV_SYNC = 2, TV_BACK = 2;
   localparam int TSHIFT = 1, TXOFF = 8, TYOFF = 4;
   localparam int H_TOT  = TH_VIS + TH_FRONT + TH_SYNC + TH_BACK;   // 288
   localparam int V_TOT  = TV_VIS + TV_FRONT + TV_SYNC + TV_BACK;   // 142

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pix_ce = 1'b0;
   logic [6:0] scan_hpos;
   logic [5:0] scan_vpos;
   logic [1:0] scan_pixel;
   logic       hsync, vsync, video_on, frame_start;
   logic [1:0] pixel_out;
   logic       mode3 = 1'b0;

   always #5 clk = ~clk;

   // VRAM model: data follows the registered address combinationally (ready next tick).
   assign scan_pixel = mode3 ? 2'd3 : scan_hpos[1:0];

   vram_scanout #(
      .H_VISIBLE(TH_VIS), .H_FRONT(TH_FRONT), .H_SYNC(TH_SYNC), .H_BACK(TH_BACK),
      .V_VISIBLE(TV_VIS), .V_FRONT(TV_FRONT), .V_SYNC(TV_SYNC), .V_BACK(TV_BACK),
      .SCALE_SHIFT(TSHIFT), .X_OFFSET(TXOFF), .Y_OFFSET(TYOFF), .SYNC_ACTIVE(1'b0)
   ) dut (
      .clk(clk), .reset(reset), .pix_ce(pix_ce),
      .scan_hpos(scan_hpos), .scan_vpos(scan_vpos), .scan_pixel(scan_pixel),
      .hsync(hsync), .vsync(vsync), .video_on(video_on),
      .pixel_out(pixel_out), .frame_start(frame_start)
   );

   typedef struct {
      int h; int v;
      bit hs; bit vs; bit vis; bit win;
      int sh; int sv;
      int act_sh; int act_sv;
   } sb_t;

   typedef struct {
      int h; int v; bit m3;
      bit hsync; bit vsync; bit video_on;
      int px; int sh; int sv;
   } row_t;

   sb_t   sb[$];
   row_t  tbl[$];
   int    tbl_hits[$];
   int    checks = 0, failures = 0;
   int    mh = 0, mv = 0, pops = 0, fs_cnt = 0;
   int    sync_err = 0, video_err = 0, pixel_err = 0, blank_err = 0, scan_err = 0, fs_err = 0;
   string sync_first = "", video_first = "", pixel_first = "", scan_first = "", fs_first = "";

   function automatic sb_t model(input int h, input int v);
      sb_t e;
      e.h   = h;
      e.v   = v;
      e.hs  = (h >= TH_VIS + TH_FRONT) && (h < TH_VIS + TH_FRONT + TH_SYNC);
      e.vs  = (v >= TV_VIS + TV_FRONT) && (v < TV_VIS + TV_FRONT + TV_SYNC);
      e.vis = (h < TH_VIS) && (v < TV_VIS);
      e.win = e.vis && (h >= TXOFF) && (h < TXOFF + (128 << TSHIFT))
                    && (v >= TYOFF) && (v < TYOFF + (64 << TSHIFT));
      e.sh  = (((h - TXOFF) & 1023) >> TSHIFT) & 127;
      e.sv  = (((v - TYOFF) & 1023) >> TSHIFT) & 63;
      e.act_sh = 0;
      e.act_sv = 0;
      return e;
   endfunction

   task automatic add_row(input int h, input int v, input bit m3, input bit hs, input bit vs,
                          input bit vid, input int px, input int sh, input int sv);
      row_t r;
      r.h = h; r.v = v; r.m3 = m3; r.hsync = hs; r.vsync = vs; r.video_on = vid;
      r.px = px; r.sh = sh; r.sv = sv;
      tbl.push_back(r);
      tbl_hits.push_back(0);
   endtask

   task automatic agg(input string name, input int act, input int req, input string note);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d %s", name, act, req, note);
      end
   endtask

   task automatic check_row(input sb_t o);
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].h == o.h && tbl[i].v == o.v && tbl[i].m3 == bit'(mode3)) begin
            checks++;
            tbl_hits[i]++;
            if (hsync !== tbl[i].hsync || vsync !== tbl[i].vsync || video_on !== tbl[i].video_on
                || pixel_out !== 2'(tbl[i].px) || o.act_sh != tbl[i].sh || o.act_sv != tbl[i].sv) begin
               failures++;
               $display("FAIL tbl[%0d] h=%0d v=%0d m3=%0d got hs=%b vs=%b vid=%b px=%0d sh=%0d sv=%0d want hs=%b vs=%b vid=%b px=%0d sh=%0d sv=%0d",
                        i, o.h, o.v, mode3, hsync, vsync, video_on, pixel_out, o.act_sh, o.act_sv,
                        tbl[i].hsync, tbl[i].vsync, tbl[i].video_on, tbl[i].px, tbl[i].sh, tbl[i].sv);
            end
         end
      end
   endtask

   // One pix_ce tick followed by low_clks idle clocks.
   task automatic do_tick(input int low_clks);
      sb_t        e, o;
      logic       exp_fs, exp_hs, exp_vs;
      logic [1:0] exp_px;
      pix_ce = 1'b1;
      @(posedge clk); #1;
      e = model(mh, mv);
      e.act_sh = int'(scan_hpos);
      e.act_sv = int'(scan_vpos);
      if (e.act_sh != e.sh || e.act_sv != e.sv) begin
         if (scan_err == 0) scan_first = $sformatf("first h=%0d v=%0d sh=%0d/%0d sv=%0d/%0d", mh, mv, e.act_sh, e.sh, e.act_sv, e.sv);
         scan_err++;
      end
      exp_fs = (mh == H_TOT - 1) && (mv == V_TOT - 1);
      if (frame_start !== exp_fs) begin
         if (fs_err == 0) fs_first = $sformatf("first h=%0d v=%0d got=%b", mh, mv, frame_start);
         fs_err++;
      end
      if (frame_start === 1'b1) fs_cnt++;
      sb.push_back(e);
      if (sb.size() >= 2) begin
         o = sb.pop_front();
         pops++;
         exp_hs = o.hs ? 1'b0 : 1'b1;
         exp_vs = o.vs ? 1'b0 : 1'b1;
         exp_px = o.win ? (mode3 ? 2'd3 : 2'(o.sh & 3)) : 2'd0;
         if (hsync !== exp_hs || vsync !== exp_vs) begin
            if (sync_err == 0) sync_first = $sformatf("first h=%0d v=%0d hs=%b/%b vs=%b/%b", o.h, o.v, hsync, exp_hs, vsync, exp_vs);
            sync_err++;
         end
         if (video_on !== o.vis) begin
            if (video_err == 0) video_first = $sformatf("first h=%0d v=%0d got=%b", o.h, o.v, video_on);
            video_err++;
         end
         if (pixel_out !== exp_px) begin
            if (pixel_err == 0) pixel_first = $sformatf("first h=%0d v=%0d got=%0d want=%0d", o.h, o.v, pixel_out, exp_px);
            pixel_err++;
         end
         if ((!o.vis || !o.win) && pixel_out !== 2'd0) blank_err++;
         check_row(o);
      end
      if (mh == H_TOT - 1) begin
         mh = 0;
         mv = (mv == V_TOT - 1) ? 0 : mv + 1;
      end else begin
         mh = mh + 1;
      end
      for (int k = 0; k < low_clks; k++) begin
         pix_ce = 1'b0;
         @(posedge clk); #1;
         if (frame_start !== 1'b0) begin
            if (fs_err == 0) fs_first = $sformatf("pulse while pix_ce low after h=%0d v=%0d", mh, mv);
            fs_err++;
         end
      end
   endtask

   task automatic restart_model();
      sb.delete();
      mh = 0;
      mv = 0;
   endtask

   initial begin
      // h, v, mode3, hsync, vsync, video_on, pixel, scan_hpos, scan_vpos
      add_row(  8,   4, 0, 1, 1, 1, 0,   0,  0);
      add_row(  9,   4, 0, 1, 1, 1, 0,   0,  0);
      add_row( 10,   4, 0, 1, 1, 1, 1,   1,  0);
      add_row( 11,   4, 0, 1, 1, 1, 1,   1,  0);
      add_row(  7,   4, 0, 1, 1, 1, 0, 127,  0);
      add_row(263,   4, 0, 1, 1, 1, 3, 127,  0);
      add_row(264,   4, 0, 1, 1, 1, 0,   0,  0);
      add_row(  8,   5, 0, 1, 1, 1, 0,   0,  0);
      add_row(  8,   6, 0, 1, 1, 1, 0,   0,  1);
      add_row(  8, 131, 0, 1, 1, 1, 0,   0, 63);
      add_row( 14, 131, 0, 1, 1, 1, 3,   3, 63);
      add_row( 14, 132, 0, 1, 1, 1, 0,   3,  0);
      add_row(271,   5, 0, 1, 1, 1, 0,   3,  0);
      add_row(272,   5, 0, 1, 1, 0, 0,   4,  0);
      add_row(275,   0, 0, 1, 1, 0, 0,   5, 62);
      add_row(276,   0, 0, 0, 1, 0, 0,   6, 62);
      add_row(283,   0, 0, 0, 1, 0, 0,   9, 62);
      add_row(284,   0, 0, 1, 1, 0, 0,  10, 62);
      add_row(  0, 135, 0, 1, 1, 1, 0, 124,  1);
      add_row(  0, 136, 0, 1, 1, 0, 0, 124,  2);
      add_row(  0, 138, 0, 1, 0, 0, 0, 124,  3);
      add_row(287, 139, 0, 1, 0, 0, 0,  11,  3);
      add_row(  0, 140, 0, 1, 1, 0, 0, 124,  4);
      add_row(  0,   0, 0, 1, 1, 1, 0, 124, 62);
      add_row(  0,   0, 1, 1, 1, 1, 0, 124, 62);
      add_row(  7,   4, 1, 1, 1, 1, 0, 127,  0);
      add_row(  8,   4, 1, 1, 1, 1, 3,   0,  0);
      add_row(264,   4, 1, 1, 1, 1, 0,   0,  0);
      add_row(280,   2, 1, 0, 1, 0, 0,   8, 63);

      // Phase A: run into the window, then reset mid-frame.
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      restart_model();
      for (int i = 0; i < 5 * H_TOT + 23; i++) do_tick(0);
      pix_ce = 1'b0;
      reset  = 1'b1;
      @(posedge clk); #1;
      agg("rst_ce_low_video_on", int'(video_on), 0, "");
      agg("rst_ce_low_pixel", int'(pixel_out), 0, "");
      agg("rst_ce_low_scan_hpos", int'(scan_hpos), 0, "");
      pix_ce = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      agg("rst_hsync", int'(hsync), 1, "");
      agg("rst_vsync", int'(vsync), 1, "");
      agg("rst_video_on", int'(video_on), 0, "");
      agg("rst_pixel", int'(pixel_out), 0, "");
      agg("rst_scan_hpos", int'(scan_hpos), 0, "");
      agg("rst_scan_vpos", int'(scan_vpos), 0, "");
      agg("rst_frame_start", int'(frame_start), 0, "");
      reset = 1'b0;
      restart_model();
      pops = 0; fs_cnt = 0;
      sync_err = 0; video_err = 0; pixel_err = 0; blank_err = 0; scan_err = 0; fs_err = 0;

      // Phase B: full continuous frame from (0,0).
      do_tick(0);
      agg("post_rst_tick1_video_on", int'(video_on), 0, "");
      agg("post_rst_tick1_hsync", int'(hsync), 1, "");
      for (int i = 1; i < H_TOT * V_TOT; i++) do_tick(0);
      agg("frame_start_pulses", fs_cnt, 1, "");

      pix_ce = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         checks++;
         if (frame_start !== 1'b0) begin
            failures++;
            $display("FAIL fs_hold clk=%0d actual=%b required=0", k, frame_start);
         end
      end

      // Blanking with VRAM forced to 3, then 1-in-4 pix_ce.
      mode3 = 1'b1;
      for (int i = 0; i < 12000; i++) do_tick(0);
      for (int i = 0; i < 1500; i++) do_tick(3);

      agg("stream_pops", pops, H_TOT * V_TOT + 12000 + 1500 - 1, "");
      agg("stream_sync", sync_err, 0, sync_first);
      agg("stream_video_on", video_err, 0, video_first);
      agg("stream_pixel", pixel_err, 0, pixel_first);
      agg("stream_blanking", blank_err, 0, "");
      agg("stream_scan_addr", scan_err, 0, scan_first);
      agg("stream_frame_start", fs_err, 0, fs_first);
      for (int i = 0; i < tbl.size(); i++) begin
         agg($sformatf("tbl_reached[%0d]", i), int'(tbl_hits[i] > 0), 1, "");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
